dmem_resp: RTL and testbench

//  Responder (target) end of the mem_in_type/mem_out_type data-memory interface: accepts single-word

---
 rtl/dmem_resp_pkg.sv | 43 ++++
 rtl/dmem_resp_if.sv | 10 +
 rtl/dmem_resp_ram.sv | 42 ++++
 rtl/dmem_resp.sv | 128 ++++++++++++
 tb/tb_dmem_resp.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types for the dmem_resp data-memory responder: bus structs, FSM
// states, RAM port structs and the stall LFSR step function.
package dmem_resp_wires;

  // Widest word index the RAM structs carry; the RAM uses the low log2(depth) bits.
  localparam int unsigned dmem_resp_idx_w = 30;

  typedef logic [dmem_resp_idx_w-1:0] dmem_resp_idx_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_resp_state_type;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef struct packed {
    logic           wen;
    logic [3:0]     wstrb;
    dmem_resp_idx_t waddr;
    dmem_resp_idx_t raddr;
    logic [31:0]    wdata;
  } dmem_resp_ram_in_type;

  typedef struct packed {
    logic [31:0] rdata;
  } dmem_resp_ram_out_type;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] dmem_resp_lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response bundle between a data-memory initiator and dmem_resp.
interface dmem_resp_if;
  import dmem_resp_wires::*;

  mem_in_type  dmem_in;
  mem_out_type dmem_out;

  modport master (output dmem_in, input  dmem_out);
  modport slave  (input  dmem_in, output dmem_out);
endinterface

// File: rtl/dmem_resp_ram.sv
// 1W/1R word RAM with per-byte write enables, registered read address and
// asynchronous array read. Contents are never reset.
module dmem_resp_ram
  import dmem_resp_wires::*;
#(
  parameter int unsigned depth = 4096
) (
  input  logic                  clock,
  input  dmem_resp_ram_in_type  ram_in,
  output dmem_resp_ram_out_type ram_out
);

  localparam int unsigned IW = $clog2(depth);

  logic [31:0]   mem_q [depth];
  logic [IW-1:0] raddr_d;
  logic [IW-1:0] raddr_q;
  logic          unused_hi;

  assign unused_hi = ^{ram_in.waddr[dmem_resp_idx_w-1:IW], ram_in.raddr[dmem_resp_idx_w-1:IW]};

  // Select the in-window part of the read index.
  always_comb begin
    raddr_d = ram_in.raddr[IW-1:0];
  end

  // Byte-masked write and read-address register.
  always_ff @(posedge clock) begin
    if (ram_in.wen) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (ram_in.wstrb[b]) mem_q[ram_in.waddr[IW-1:0]][8*b +: 8] <= ram_in.wdata[8*b +: 8];
      end
    end
    raddr_q <= raddr_d;
  end

  // Asynchronous read of the registered address.
  always_comb begin
    ram_out.rdata = mem_q[raddr_q];
  end

endmodule

// File: rtl/dmem_resp.sv
// Responder end of the data-memory interface: accepts one request at a time,
// answers with a single-cycle mem_ready after a fixed latency.
// Optional feature macro: DMEM_RESP_STALL_EN adds 0..3 LFSR-driven stall cycles.
module dmem_resp
  import dmem_resp_wires::*;
#(
  parameter int unsigned dmem_resp_depth = 4096,
  parameter logic [31:0] dmem_resp_base  = 32'h0,
  parameter int unsigned dmem_resp_lat   = 2
) (
  input logic         reset,
  input logic         clock,
  dmem_resp_if.slave  dmem
);

  localparam int unsigned IW = $clog2(dmem_resp_depth);
  localparam int unsigned AW = IW + 2;

  dmem_resp_state_type   state_d, state_q;
  logic [4:0]            count_d, count_q;
  logic [IW-1:0]         idx_d, idx_q;
  logic                  rd_d, rd_q;
  logic                  accept;
  logic                  in_range;
  logic [1:0]            extra;
  logic [4:0]            total;
  dmem_resp_ram_in_type  ram_in;
  dmem_resp_ram_out_type ram_out;
  mem_out_type           resp;
  logic                  unused_req;

  assign unused_req = ^{dmem.dmem_in.mem_instr, dmem.dmem_in.mem_addr[1:0]};

  // Base is aligned to the window size, so the range test is a tag compare.
  assign in_range = dmem.dmem_in.mem_addr[31:AW] == dmem_resp_base[31:AW];
  assign accept   = (state_q != BUSY) && dmem.dmem_in.mem_valid;

`ifdef DMEM_RESP_STALL_EN
  logic [7:0] lfsr_d, lfsr_q;

  // Step the stall LFSR once per accepted request.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = dmem_resp_lfsr_next(lfsr_q);
  end

  // Stall LFSR register, reseeded on reset.
  always_ff @(posedge clock) begin
    if (!reset) lfsr_q <= 8'h5A;
    else        lfsr_q <= lfsr_d;
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'b00;
`endif

  assign total = 5'(dmem_resp_lat) + {3'b000, extra};

  // Next-state, latency counter, request latch and RAM port drive.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    ram_in  = '0;

    case (state_q)
      BUSY: begin
        if (count_q == '0) state_d = RESP;
        else               count_d = count_q - 5'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      idx_d = dmem.dmem_in.mem_addr[2 +: IW];
      rd_d  = in_range && !dmem.dmem_in.mem_fence && (dmem.dmem_in.mem_wstrb == '0);
      if (total == 5'd1) begin
        state_d = RESP;
      end else begin
        state_d = BUSY;
        count_d = total - 5'd2;
      end
      ram_in.wen   = in_range && !dmem.dmem_in.mem_fence && (dmem.dmem_in.mem_wstrb != '0);
      ram_in.wstrb = dmem.dmem_in.mem_wstrb;
      ram_in.wdata = dmem.dmem_in.mem_wdata;
      ram_in.waddr = dmem_resp_idx_t'(idx_d);
    end

    // Read address follows the latched index so it stays put until the response.
    ram_in.raddr = dmem_resp_idx_t'(idx_d);
  end

  // FSM and request registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
    end
  end

  dmem_resp_ram #(
    .depth (dmem_resp_depth)
  ) u_ram (
    .clock   (clock),
    .ram_in  (ram_in),
    .ram_out (ram_out)
  );

  // Response: ready straight from the state register, data only for in-range reads.
  always_comb begin
    resp           = '0;
    resp.mem_ready = (state_q == RESP);
    if ((state_q == RESP) && rd_q) resp.mem_rdata = ram_out.rdata;
  end

  assign dmem.dmem_out = resp;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: one instance at latency 2, one at latency 1.
module tb_dmem_resp;
  import dmem_resp_wires::*;

  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_resp_if ifa ();
  dmem_resp_if ifb ();

  dmem_resp #(.dmem_resp_depth(4096), .dmem_resp_base(32'h0), .dmem_resp_lat(LAT_A))
    dut_a (.reset(reset), .clock(clock), .dmem(ifa));
  dmem_resp #(.dmem_resp_depth(4096), .dmem_resp_base(32'h0), .dmem_resp_lat(LAT_B))
    dut_b (.reset(reset), .clock(clock), .dmem(ifb));

  typedef struct {
    logic [31:0] rdata;
    bit          chained;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        fence;
    logic [31:0] exp;
  } req_t;

  exp_t sbq_a[$];
  exp_t sbq_b[$];
  req_t reqs[$];
  int   last_ready[2];
  logic [7:0] lf_model[2];
  int   passed = 0;
  int   total  = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ifa.dmem_out.mem_ready : ifb.dmem_out.mem_ready;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? sbq_a.size() : sbq_b.size();
  endfunction

  function automatic req_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic fence, input logic [31:0] exp);
    req_t r;
    r.addr = addr; r.wdata = wdata; r.wstrb = wstrb; r.fence = fence; r.exp = exp;
    return r;
  endfunction

  task automatic drive(input int sel, input req_t r, input logic v);
    mem_in_type m;
    m.mem_valid = v;
    m.mem_fence = r.fence;
    m.mem_instr = 1'b0;
    m.mem_addr  = r.addr;
    m.mem_wdata = r.wdata;
    m.mem_wstrb = r.wstrb;
    if (sel == 0) ifa.dmem_in = m;
    else          ifb.dmem_in = m;
  endtask

  // Expected latency = base latency plus the stall the reference LFSR predicts.
  task automatic push(input int sel, input logic [31:0] d, input bit chained);
    exp_t e;
    int   extra;
    extra = 0;
`ifdef DMEM_RESP_STALL_EN
    extra = int'(lf_model[sel][1:0]);
    lf_model[sel] = {lf_model[sel][6:0],
                     lf_model[sel][7] ^ lf_model[sel][5] ^ lf_model[sel][4] ^ lf_model[sel][3]};
`endif
    e.rdata   = d;
    e.chained = chained;
    e.acc     = cyc;
    e.lat     = ((sel == 0) ? int'(LAT_A) : int'(LAT_B)) + extra;
    if (sel == 0) sbq_a.push_back(e);
    else          sbq_b.push_back(e);
  endtask

  task automatic wait_ready(input int sel);
    int n;
    n = 0;
    while (!rdy(sel) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!rdy(sel)) fail_now("ready_timeout");
  endtask

  // Holds mem_valid across the whole list; each request after the first is
  // taken in the cycle the previous response is presented.
  task automatic run_chain(input int sel);
    for (int i = 0; i < reqs.size(); i++) begin
      drive(sel, reqs[i], 1'b1);
      push(sel, reqs[i].exp, i != 0);
      if (i != 0) wait_ready(sel);
      @(negedge clock);
    end
    drive(sel, mk(32'h0, 32'h0, 4'h0, 1'b0, 32'h0), 1'b0);
    reqs.delete();
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (qsize(sel) > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (qsize(sel) > 0) fail_now("drain_timeout");
    @(negedge clock);
  endtask

  task automatic single(input int sel, input req_t r);
    reqs.push_back(r);
    run_chain(sel);
    drain(sel);
  endtask

  task automatic mon(input int sel, input logic r, input logic [31:0] d);
    exp_t e;
    int   acc;
    if (r) begin
      if (qsize(sel) == 0) begin
        fail_now($sformatf("unexpected_ready dut%0d", sel));
      end else begin
        if (sel == 0) e = sbq_a.pop_front();
        else          e = sbq_b.pop_front();
        acc = e.chained ? last_ready[sel] : e.acc;
        chk($sformatf("rdata dut%0d", sel), d, e.rdata);
        chk($sformatf("latency dut%0d", sel), 32'(cyc - acc), 32'(e.lat));
        last_ready[sel] = cyc;
      end
    end else begin
      chk($sformatf("idle_rdata dut%0d", sel), d, 32'h0);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon(0, ifa.dmem_out.mem_ready, ifa.dmem_out.mem_rdata);
      mon(1, ifb.dmem_out.mem_ready, ifb.dmem_out.mem_rdata);
    end
  end

  initial begin
    lf_model[0] = 8'h5A;
    lf_model[1] = 8'h5A;
    ifa.dmem_in = '0;
    ifb.dmem_in = '0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_ready_a", 32'(ifa.dmem_out.mem_ready), 32'h0);
    chk("reset_rdata_a", ifa.dmem_out.mem_rdata, 32'h0);
    chk("reset_ready_b", 32'(ifb.dmem_out.mem_ready), 32'h0);
    chk("reset_rdata_b", ifb.dmem_out.mem_rdata, 32'h0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);

    // Full write then read, latency 2.
    reqs.push_back(mk(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0));
    reqs.push_back(mk(32'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF));
    run_chain(0);
    drain(0);

    // Byte strobes.
    reqs.push_back(mk(32'h14, 32'h11223344, 4'hF,    1'b0, 32'h0));
    reqs.push_back(mk(32'h14, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0));
    reqs.push_back(mk(32'h14, 32'h0,        4'h0,    1'b0, 32'h11BB33DD));
    reqs.push_back(mk(32'h18, 32'h0,        4'hF,    1'b0, 32'h0));
    reqs.push_back(mk(32'h18, 32'hCAFEF00D, 4'b0110, 1'b0, 32'h0));
    reqs.push_back(mk(32'h18, 32'h0,        4'h0,    1'b0, 32'h00FEF000));
    run_chain(0);
    drain(0);

    // Latency 1, valid held: one response per cycle, write visible to next read.
    reqs.push_back(mk(32'h20, 32'h00000055, 4'hF, 1'b0, 32'h0));
    reqs.push_back(mk(32'h20, 32'h0,        4'h0, 1'b0, 32'h00000055));
    reqs.push_back(mk(32'h24, 32'h00001234, 4'hF, 1'b0, 32'h0));
    reqs.push_back(mk(32'h24, 32'h0,        4'h0, 1'b0, 32'h00001234));
    reqs.push_back(mk(32'h20, 32'h0,        4'h0, 1'b0, 32'h00000055));
    run_chain(1);
    drain(1);

    // Out of range (0x4010 aliases index of 0x10) and fences: rdata 0, RAM untouched.
    single(0, mk(32'h4010, 32'h0,        4'h0, 1'b0, 32'h0));
    single(0, mk(32'h4010, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0));
    single(0, mk(32'h10,   32'h0,        4'hF, 1'b1, 32'h0));
    single(0, mk(32'h10,   32'h0,        4'h0, 1'b1, 32'h0));
    single(0, mk(32'h10,   32'h0,        4'h0, 1'b0, 32'hDEADBEEF));
    single(0, mk(32'h80000010, 32'h0,    4'h0, 1'b0, 32'h0));

    // Reset while BUSY: pending response dropped, RAM kept.
    drive(0, mk(32'h14, 32'h0, 4'h0, 1'b0, 32'h0), 1'b1);
    @(negedge clock);
    drive(0, mk(32'h0, 32'h0, 4'h0, 1'b0, 32'h0), 1'b0);
    reset = 1'b0;
    lf_model[0] = 8'h5A;
    lf_model[1] = 8'h5A;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("no_ready_after_reset", 32'(ifa.dmem_out.mem_ready), 32'h0);
      @(negedge clock);
    end
    single(0, mk(32'h14, 32'h0, 4'h0, 1'b0, 32'h11BB33DD));

    // Long read streams: latency sequence under stalls, plain latency otherwise.
    for (int i = 0; i < 32; i++) reqs.push_back(mk(32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF));
    run_chain(0);
    drain(0);
    for (int i = 0; i < 8; i++) reqs.push_back(mk(32'h24, 32'h0, 4'h0, 1'b0, 32'h00001234));
    run_chain(1);
    drain(1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
